// File: rtl/pipe_arith_pkg.sv
// pipe_arith_pkg: mode encodings shared by the arithmetic stream pipeline
package pipe_arith_pkg;
    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_X1  = 2'b10,
        MODE_X2  = 2'b11
    } mode_e;
endpackage

// File: rtl/pipe_arith_stream_if.sv
// pipe_arith_stream_if: operand/result handshake bundle for pipe_arith_stream
interface pipe_arith_stream_if #(parameter int N = 16);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic [N-1:0]   C;
    logic [N-1:0]   D;
    logic [1:0]     mode;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] F;
    logic [1:0]     occupancy;
    modport master (
        output in_valid, A, B, C, D, mode, out_ready,
        input  in_ready, out_valid, F, occupancy
    );
    modport slave (
        input  in_valid, A, B, C, D, mode, out_ready,
        output in_ready, out_valid, F, occupancy
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one elastic pipeline stage that loads when empty or when its successor drains it
module pipe_stage_reg #(
    parameter int WIDTH      = 8,
    parameter bit RESET_DATA = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] d,
    input  logic             next_load,
    output logic             load,
    output logic             valid,
    output logic             valid_nxt,
    output logic [WIDTH-1:0] q
);
    assign load      = !valid || next_load;
    assign valid_nxt = load ? in_valid : valid;
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            if (RESET_DATA) q <= '0;
        end else begin
            valid <= valid_nxt;
            if (load && in_valid) q <= d;
        end
    end
endmodule

// File: rtl/pipe_arith_stream.sv
// pipe_arith_stream: three-stage elastic pipeline computing F = f(A+B, C-D) * D
module pipe_arith_stream
    import pipe_arith_pkg::*;
#(
    parameter int N           = 16,
    parameter int OP_MODES_EN = 1
) (
    input logic               clk,
    input logic               rst,
    pipe_arith_stream_if.slave s
);
    localparam int W1 = 3 * N + 2;
    logic [N-1:0]   x1, x2, x1_q, x2_q, d1, x3, x3_q, d2;
    logic [1:0]     m_in, m_q;
    logic [W1-1:0]  s1_q;
    logic [2*N-1:0] s2_q, f_d, f_q;
    logic           ld1, ld2, ld3, v1, v2, v3, vn1, vn2, vn3;
    logic [1:0]     occ;
    always_comb begin
        m_in = (OP_MODES_EN != 0) ? s.mode : MODE_ADD;
        x1   = s.A + s.B;
        x2   = s.C - s.D;
        x3   = m_q == MODE_ADD ? x1_q + x2_q :
               m_q == MODE_SUB ? x1_q - x2_q :
               m_q == MODE_X1  ? x1_q : x2_q;
        f_d  = {{N{1'b0}}, x3_q} * {{N{1'b0}}, d2};
    end
    assign {x1_q, x2_q, d1, m_q} = s1_q;
    assign {x3_q, d2}            = s2_q;
    pipe_stage_reg #(.WIDTH(W1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(s.in_valid), .d({x1, x2, s.D, m_in}),
        .next_load(ld2), .load(ld1), .valid(v1), .valid_nxt(vn1), .q(s1_q)
    );
    pipe_stage_reg #(.WIDTH(2 * N)) u_s2 (
        .clk(clk), .rst(rst), .in_valid(v1), .d({x3, d1}),
        .next_load(ld3), .load(ld2), .valid(v2), .valid_nxt(vn2), .q(s2_q)
    );
    // Only the result register is cleared so F reads 0 straight after reset
    pipe_stage_reg #(.WIDTH(2 * N), .RESET_DATA(1'b1)) u_s3 (
        .clk(clk), .rst(rst), .in_valid(v2), .d(f_d),
        .next_load(s.out_ready), .load(ld3), .valid(v3), .valid_nxt(vn3), .q(f_q)
    );
    always_ff @(posedge clk) begin
        occ <= rst ? 2'd0 : 2'(vn1) + 2'(vn2) + 2'(vn3);
    end
    assign s.in_ready  = ld1 && !rst;
    assign s.out_valid = v3;
    assign s.F         = f_q;
    assign s.occupancy = occ;
endmodule

// File: tb/tb_pipe_arith_stream.sv
// tb_pipe_arith_stream: scoreboard bench for pipe_arith_stream at N = 8
module tb_pipe_arith_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_arith_stream_if #(.N(8)) bus ();
    pipe_arith_stream #(.N(8), .OP_MODES_EN(1)) dut (.clk(clk), .rst(rst), .s(bus));

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_out_cyc = 0;
    int pushes = 0;
    int pops = 0;
    logic [15:0] sb[$];
    logic hold = 1'b0;
    logic [15:0] held_f = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] a, b, c, d, input logic [1:0] m);
        logic [7:0] x1, x2, x3;
        x1 = a + b;
        x2 = c - d;
        x3 = m == 2'b00 ? x1 + x2 : m == 2'b01 ? x1 - x2 : m == 2'b10 ? x1 : x2;
        return {8'b0, x3} * {8'b0, d};
    endfunction

    task automatic step(input logic iv, input logic orr, input logic [7:0] a, b, c, d,
                        input logic [1:0] m, input logic [15:0] exp);
        @(negedge clk);
        cyc++;
        bus.in_valid = iv;
        bus.out_ready = orr;
        bus.A = a;
        bus.B = b;
        bus.C = c;
        bus.D = d;
        bus.mode = m;
        #1;
        chk("occupancy", 32'(bus.occupancy), 32'(sb.size()));
        if (hold) chk("f_stable", 32'(bus.F), 32'(held_f));
        hold = bus.out_valid && !orr;
        held_f = bus.F;
        if (bus.out_valid && orr) begin
            if (sb.size() == 0) chk("spurious_out", 32'(bus.F), 32'hFFFF_FFFF);
            else chk("F", 32'(bus.F), 32'(sb.pop_front()));
            pops++;
            last_out_cyc = cyc;
        end
        if (iv && bus.in_ready) begin
            sb.push_back(exp);
            pushes++;
        end
    endtask

    task automatic rstep(input logic iv, input logic orr);
        logic [7:0] a, b, c, d;
        logic [1:0] m;
        a = 8'($urandom);
        b = 8'($urandom);
        c = 8'($urandom);
        d = 8'($urandom);
        m = 2'($urandom);
        step(iv, orr, a, b, c, d, m, model(a, b, c, d, m));
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) rstep(1'b0, 1'b1);
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int t0, target, guard, p0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.C = '0;
        bus.D = '0;
        bus.mode = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
        chk("rst_F", 32'(bus.F), 32'd0);
        rst = 1'b0;

        step(1'b1, 1'b1, 8'd3, 8'd4, 8'd10, 8'd2, 2'b00, 16'd30);
        t0 = cyc;
        repeat (5) rstep(1'b0, 1'b1);
        chk("latency", 32'(last_out_cyc - t0), 32'd3);
        step(1'b1, 1'b1, 8'd3, 8'd4, 8'd10, 8'd2, 2'b01, 16'd510);
        step(1'b1, 1'b1, 8'd200, 8'd100, 8'd0, 8'd1, 2'b00, 16'd43);
        step(1'b1, 1'b1, 8'd255, 8'd255, 8'd255, 8'd255, 2'b10, 16'd64770);
        step(1'b1, 1'b1, 8'd1, 8'd2, 8'd9, 8'd4, 2'b11, 16'd20);
        drain();

        for (int i = 0; i < 6; i++) rstep(1'b1, 1'b0);
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        chk("stall_accepted", 32'(sb.size()), 32'd3);
        rstep(1'b1, 1'b1);
        rstep(1'b0, 1'b1);
        chk("full_swap_occ", 32'(bus.occupancy), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("no_gap", 32'(bus.out_valid), 32'd1);
            rstep(1'b0, 1'b1);
        end
        drain();

        target = pushes + 1000;
        guard = 0;
        while (pushes < target && guard < 20000) begin
            rstep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            guard++;
        end
        chk("random_budget", 32'(pushes >= target), 32'd1);
        drain();

        rstep(1'b1, 1'b0);
        rstep(1'b1, 1'b0);
        @(negedge clk);
        cyc++;
        chk("pre_rst_occ", 32'(bus.occupancy), 32'd2);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        chk("rst_cycle_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("post_rst_occ", 32'(bus.occupancy), 32'd0);
        chk("post_rst_F", 32'(bus.F), 32'd0);
        sb.delete();
        hold = 1'b0;
        p0 = pops;
        step(1'b1, 1'b1, 8'd5, 8'd6, 8'd7, 8'd3, 2'b00, 16'd45);
        repeat (6) rstep(1'b0, 1'b1);
        chk("post_rst_count", 32'(pops - p0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
